// File: rtl/fp_add_sub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with a valid/ready handshake.
// Define FP_ADD_SUB_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_add_sub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         exception,
  output logic         overflow,
  output logic         underflow
);
  localparam int unsigned MW   = MAN_W + 1;
  localparam int unsigned RW   = MW + 1;
  localparam int unsigned AW   = MAN_W + 4;
  localparam int unsigned LZW  = $clog2(AW + 1);
  localparam int unsigned EW   = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  logic             r_s1_valid, r_s1_exc, r_s1_sx, r_s1_sy;
  logic [EXP_W-1:0] r_s1_ex, r_s1_d;
  logic [MW-1:0]    r_s1_mx, r_s1_my;
  logic             r_s2_valid, r_s2_exc, r_s2_sx, r_s2_eff_sub;
  logic [EXP_W-1:0] r_s2_ex;
  logic [AW-1:0]    r_s2_mx, r_s2_my;
  logic             r_s3_valid, r_s3_exc, r_s3_sign;
  logic [EXP_W-1:0] r_s3_ex;
  logic [AW:0]      r_s3_sum;
  logic             r_out_valid, r_exc, r_ovf, r_unf;
  logic [W-1:0]     r_result;

  logic w_advance;
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign exception = r_exc;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

  // S1: unpack, order operands so X holds the larger magnitude
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_ge;
  assign w_ea   = a[W-2 -: EXP_W];
  assign w_eb   = b[W-2 -: EXP_W];
  assign w_fa   = a[MAN_W-1:0];
  assign w_fb   = b[MAN_W-1:0];
  assign w_a_ge = {w_ea, w_fa} >= {w_eb, w_fb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0; r_s1_exc <= 1'b0; r_s1_sx <= 1'b0; r_s1_sy <= 1'b0;
      r_s1_ex <= '0; r_s1_d <= '0; r_s1_mx <= '0; r_s1_my <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_exc   <= (&w_ea) | (&w_eb);
      if (w_a_ge) begin
        r_s1_sx <= a[W-1];       r_s1_sy <= b[W-1] ^ sub;
        r_s1_ex <= w_ea;         r_s1_d  <= w_ea - w_eb;
        r_s1_mx <= {|w_ea, w_fa}; r_s1_my <= {|w_eb, w_fb};
      end else begin
        r_s1_sx <= b[W-1] ^ sub; r_s1_sy <= a[W-1];
        r_s1_ex <= w_eb;         r_s1_d  <= w_eb - w_ea;
        r_s1_mx <= {|w_eb, w_fb}; r_s1_my <= {|w_ea, w_fa};
      end
    end
  end

  // S2: align Y into mantissa+G/R/S; everything shifted out folds into sticky
  logic [AW-1:0] w_y_ext, w_y_sh, w_mask, w_y_al;
  assign w_y_ext = {r_s1_my, 3'b000};
  assign w_y_sh  = w_y_ext >> r_s1_d;
  assign w_mask  = ~({AW{1'b1}} << r_s1_d);
  assign w_y_al  = (32'(r_s1_d) >= 32'(MAN_W + 3)) ? AW'(|r_s1_my)
                 : (w_y_sh | AW'(|(w_y_ext & w_mask)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0; r_s2_exc <= 1'b0; r_s2_sx <= 1'b0; r_s2_eff_sub <= 1'b0;
      r_s2_ex <= '0; r_s2_mx <= '0; r_s2_my <= '0;
    end else if (w_advance) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_exc     <= r_s1_exc;
      r_s2_sx      <= r_s1_sx;
      r_s2_eff_sub <= r_s1_sx ^ r_s1_sy;
      r_s2_ex      <= r_s1_ex;
      r_s2_mx      <= {r_s1_mx, 3'b000};
      r_s2_my      <= w_y_al;
    end
  end

  // S3: magnitude add/subtract; the S1 swap keeps the difference non-negative
  logic [AW:0] w_sum;
  assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_mx} - {1'b0, r_s2_my})
                              : ({1'b0, r_s2_mx} + {1'b0, r_s2_my});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_valid <= 1'b0; r_s3_exc <= 1'b0; r_s3_sign <= 1'b0;
      r_s3_ex <= '0; r_s3_sum <= '0;
    end else if (w_advance) begin
      r_s3_valid <= r_s2_valid;
      r_s3_exc   <= r_s2_exc;
      r_s3_sign  <= r_s2_sx;
      r_s3_ex    <= r_s2_ex;
      r_s3_sum   <= w_sum;
    end
  end

  // S4: normalise, round, then apply the special-case overrides
  logic [LZW-1:0]       w_lzc;
  logic [AW-1:0]        w_norm;
  logic signed [EW-1:0] w_exp_n, w_exp_f;
  logic [RW-1:0]        w_rnd;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_zero;

  always_comb begin
    w_lzc = LZW'(AW);
    for (int i = 0; i < int'(AW); i++)
      if (r_s3_sum[i]) w_lzc = LZW'(int'(AW) - 1 - i);
  end

  always_comb begin
    w_norm  = '0;
    w_exp_n = '0;
    if (r_s3_sum[AW]) begin
      w_norm  = {r_s3_sum[AW:2], r_s3_sum[1] | r_s3_sum[0]};
      w_exp_n = $signed(EW'(r_s3_ex)) + $signed(EW'(1));
    end else begin
      w_norm  = r_s3_sum[AW-1:0] << w_lzc;
      w_exp_n = $signed(EW'(r_s3_ex)) - $signed(EW'(w_lzc));
    end
  end

`ifdef FP_ADD_SUB_RNE_EN
  assign w_rnd = {1'b0, w_norm[AW-1:3]}
               + RW'(w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]));
`else
  logic w_unused_grs;
  assign w_rnd        = {1'b0, w_norm[AW-1:3]};
  assign w_unused_grs = ^w_norm[2:0];
`endif

  assign w_exp_f = w_rnd[MW] ? (w_exp_n + $signed(EW'(1))) : w_exp_n;
  assign w_frac  = w_rnd[MW] ? w_rnd[MW-1:1] : w_rnd[MAN_W-1:0];
  assign w_zero  = (r_s3_sum == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0; r_result <= '0;
      r_exc <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s3_valid;
      r_exc <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
      if (r_s3_exc) begin
        r_result <= '1;
        r_exc    <= 1'b1;
      end else if (w_zero) begin
        r_result <= '0;
      end else if (w_exp_f >= $signed(EW'(EMAX))) begin
        r_result <= {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        r_ovf    <= 1'b1;
      end else if (w_exp_f <= $signed(EW'(0))) begin
        r_result <= {r_s3_sign, {(W-1){1'b0}}};
        r_unf    <= 1'b1;
      end else begin
        r_result <= {r_s3_sign, w_exp_f[EXP_W-1:0], w_frac};
      end
    end
  end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed scoreboard bench for fp_add_sub_pipe (single precision defaults).
module tb_fp_add_sub_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic        exception, overflow, underflow;
  logic [31:0] a, b, result;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;  // {exception, overflow, underflow}
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          popped = 0;
  int          popped0;
  int          lat;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res = '0;
  logic [31:0] ftab [0:9];

`ifdef FP_ADD_SUB_RNE_EN
  localparam logic [31:0] T5_RES = 32'h3F800002;
`else
  localparam logic [31:0] T5_RES = 32'h3F800001;
`endif

  fp_add_sub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one operand pair from posedge+1 and push its expectation once accepted
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                      input logic [31:0] eres, input logic [2:0] eflg);
    bit acc = 1'b0;
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk);
    end
    if (acc) q.push_back({eres, eflg});
    else chk("accept_timeout", in_ready, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
    chk("drain", q.size(), 0);
    #1;
  endtask

  // Scoreboard: compare on each handshake, check hold behaviour while stalled
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        if (prev_hold) chk("hold_stable", result, prev_res);
        prev_hold = 1'b1;
        prev_res  = result;
      end else begin
        prev_hold = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_output", out_valid, 0);
        end else begin
          mon_e = q.pop_front();
          chk($sformatf("result#%0d", popped), result, mon_e.res);
          chk($sformatf("flags#%0d", popped), {exception, overflow, underflow}, mon_e.flg);
          popped++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ftab[0] = 32'h3F800000; ftab[1] = 32'h40000000; ftab[2] = 32'h40400000;
    ftab[3] = 32'h40800000; ftab[4] = 32'h40A00000; ftab[5] = 32'h40C00000;
    ftab[6] = 32'h40E00000; ftab[7] = 32'h41000000; ftab[8] = 32'h41100000;
    ftab[9] = 32'h41200000;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {exception, overflow, underflow}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // 1.0 + 2.0 with latency measured from the accepting edge (counted as 1)
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); chk("in_ready_idle", in_ready, 1);
    @(posedge clk); q.push_back({32'h40400000, 3'b000});
    #1 in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    @(posedge clk); #1;
    drain();

    send(32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 3'b000);  // 3 - 5
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);  // exact zero
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);  // overflow
    send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);  // underflow
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'hFFFFFFFF, 3'b100);  // exception
    send(32'h3F800001, 32'h33800000, 1'b0, T5_RES, 3'b000);        // tie case
    send(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000);  // -2 + 1
    drain();

    // Back-to-back stream with a 5-cycle downstream stall
    popped0 = popped;
    fork
      for (int i = 0; i < 8; i++) send(ftab[i], ftab[0], 1'b0, ftab[i+1], 3'b000);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", popped - popped0, 8);

    // Reset with operations in flight: all must be discarded
    for (int i = 0; i < 3; i++) send(ftab[i], ftab[0], 1'b0, ftab[i+1], 3'b000);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flushed_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    popped0 = popped;
    send(ftab[2], ftab[1], 1'b1, ftab[0], 3'b000);  // 3 - 2
    drain();
    chk("post_rst_count", popped - popped0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
